// File: rtl/seq_priority_encoder_if.sv
// Handshake bundle for seq_priority_encoder: vector input side and index output side.
interface seq_priority_encoder_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned W = $clog2(N);

  // Vector input channel
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;

  // Index output channel
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;
  logic         out_none;

  // Producer of vectors / consumer of indices
  modport master (
    output in_valid,
    output in_vec,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_last,
    input  out_none
  );

  // The encoder itself
  modport slave (
    input  in_valid,
    input  in_vec,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_last,
    output out_none
  );
endinterface

// File: rtl/seq_priority_encoder.sv
// Sequential priority encoder: accepts an N-bit request vector, then emits the index of
// every set bit one beat at a time in MSB-first or LSB-first order. An all-zero vector
// yields a single "none" beat. Downstream may stall via out_ready; flush aborts a vector.
module seq_priority_encoder #(
  parameter int unsigned N         = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  output logic                  busy,
  seq_priority_encoder_if.slave bus
);

  localparam int unsigned W = $clog2(N);

  typedef enum logic [0:0] {
    StIdle,
    StEmit
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic         zero_q, zero_d;

  logic [W-1:0] sel_idx;
  logic [N-1:0] sel_mask;
  logic         single;
  logic         emitting;
  logic         accept;
  logic         beat;

  // Pick the highest (or lowest) set bit of the pending vector.
  always_comb begin
    sel_idx = '0;
    if (MSB_FIRST) begin
      // Ascending scan: last hit is the highest set bit.
      for (int i = 0; i < int'(N); i++) begin
        if (pend_q[i]) sel_idx = W'(i);
      end
    end else begin
      // Descending scan: last hit is the lowest set bit.
      for (int i = int'(N) - 1; i >= 0; i--) begin
        if (pend_q[i]) sel_idx = W'(i);
      end
    end
  end

  // Derived beat information: bit to clear and whether this is the final beat.
  always_comb begin
    sel_mask = {{(N-1){1'b0}}, 1'b1} << sel_idx;
    // Zero or one bit left; x & (x-1) strips the lowest set bit.
    single   = ((pend_q & (pend_q - {{(N-1){1'b0}}, 1'b1})) == '0);
    emitting = (state_q == StEmit);
    accept   = bus.in_valid && bus.in_ready;
    beat     = emitting && bus.out_ready;
  end

  // Handshake and status outputs; idx/last/none are forced to zero outside EMIT.
  always_comb begin
    bus.in_ready  = (state_q == StIdle) && !flush;
    bus.out_valid = emitting;
    bus.out_idx   = emitting ? sel_idx : '0;
    bus.out_last  = emitting && single;
    bus.out_none  = emitting && zero_q;
    busy          = emitting;
  end

  // Next-state logic; flush takes precedence over a coincident beat.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = zero_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          pend_d  = bus.in_vec;
          zero_d  = (bus.in_vec == '0);
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (flush) begin
          pend_d  = '0;
          zero_d  = 1'b0;
          state_d = StIdle;
        end else if (beat) begin
          pend_d = pend_q & ~sel_mask;
          if (single) begin
            pend_d  = '0;
            zero_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
        pend_d  = '0;
        zero_d  = 1'b0;
      end
    endcase
  end

  // State and pending-vector registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pend_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Bench for seq_priority_encoder: three instances (N=8 MSB-first, N=8 LSB-first,
// N=16 MSB-first) share one stimulus stream and are checked against a queue-based model.
module tb_seq_priority_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] vec = '0;

  logic busy0, busy1, busy2;

  int checks = 0;
  int failures = 0;

  // Model: per instance, the list of indices still to be emitted (-1 = "none" beat).
  int exp_q[3][$];
  bit act[3];

  always #5 clk = ~clk;

  seq_priority_encoder_if #(.N(8))  if0 ();
  seq_priority_encoder_if #(.N(8))  if1 ();
  seq_priority_encoder_if #(.N(16)) if2 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_vec    = vec[7:0];
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.in_vec    = vec[7:0];
  assign if1.out_ready = out_ready;
  assign if2.in_valid  = in_valid;
  assign if2.in_vec    = vec;
  assign if2.out_ready = out_ready;

  seq_priority_encoder #(.N(8), .MSB_FIRST(1'b1)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy0),
    .bus   (if0)
  );

  seq_priority_encoder #(.N(8), .MSB_FIRST(1'b0)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy1),
    .bus   (if1)
  );

  seq_priority_encoder #(.N(16), .MSB_FIRST(1'b1)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .busy  (busy2),
    .bus   (if2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic get_obs(input int m, output logic [31:0] v, output logic [31:0] idx,
                         output logic [31:0] last, output logic [31:0] none,
                         output logic [31:0] rdy, output logic [31:0] bsy);
    case (m)
      0: begin
        v = 32'(if0.out_valid); idx = 32'(if0.out_idx); last = 32'(if0.out_last);
        none = 32'(if0.out_none); rdy = 32'(if0.in_ready); bsy = 32'(busy0);
      end
      1: begin
        v = 32'(if1.out_valid); idx = 32'(if1.out_idx); last = 32'(if1.out_last);
        none = 32'(if1.out_none); rdy = 32'(if1.in_ready); bsy = 32'(busy1);
      end
      default: begin
        v = 32'(if2.out_valid); idx = 32'(if2.out_idx); last = 32'(if2.out_last);
        none = 32'(if2.out_none); rdy = 32'(if2.in_ready); bsy = 32'(busy2);
      end
    endcase
  endtask

  // Build the expected beat list for a newly accepted vector.
  task automatic load(input int m, input logic [15:0] v);
    int  n   = (m == 2) ? 16 : 8;
    bit  msb = (m != 1);
    exp_q[m].delete();
    for (int k = 0; k < n; k++) begin
      int i = msb ? (n - 1 - k) : k;
      if (v[i]) exp_q[m].push_back(i);
    end
    if (exp_q[m].size() == 0) exp_q[m].push_back(-1);
  endtask

  task automatic check_inst(input int m);
    logic [31:0] v, idx, last, none, rdy, bsy;
    int front;
    get_obs(m, v, idx, last, none, rdy, bsy);
    front = act[m] ? exp_q[m][0] : 0;
    check_eq($sformatf("i%0d_out_valid", m), v, 32'(act[m]));
    check_eq($sformatf("i%0d_out_idx", m), idx, (act[m] && front >= 0) ? 32'(front) : 0);
    check_eq($sformatf("i%0d_out_last", m), last, 32'(act[m] && exp_q[m].size() == 1));
    check_eq($sformatf("i%0d_out_none", m), none, 32'(act[m] && front < 0));
    check_eq($sformatf("i%0d_in_ready", m), rdy, 32'(!act[m] && !flush));
    check_eq($sformatf("i%0d_busy", m), bsy, 32'(act[m]));
  endtask

  task automatic model_update();
    for (int m = 0; m < 3; m++) begin
      if (act[m]) begin
        if (flush) begin
          act[m] = 1'b0;
          exp_q[m].delete();
        end else if (out_ready) begin
          void'(exp_q[m].pop_front());
          if (exp_q[m].size() == 0) act[m] = 1'b0;
        end
      end else if (in_valid && !flush) begin
        load(m, (m == 2) ? vec : {8'h00, vec[7:0]});
        act[m] = 1'b1;
      end
    end
  endtask

  // One clock: check at the falling edge, advance the model, settle past the rising edge.
  task automatic step();
    @(negedge clk);
    if (rst_n) begin
      for (int m = 0; m < 3; m++) check_inst(m);
      model_update();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v);
    vec      = v;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 40 && (act[0] || act[1] || act[2]); i++) step();
    check_eq("drain_idle", 32'(busy0 | busy1 | busy2), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    #2;
    for (int m = 0; m < 3; m++) check_inst(m);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // One-hot sweep
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      send(16'(1) << k);
      drain();
    end

    // Multi-bit vector, full throughput
    send(16'h00A5);
    drain();

    // Backpressure for 3 cycles once the first beat is up
    out_ready = 1'b0;
    send(16'h00A5);
    for (int i = 0; i < 3; i++) step();
    drain();

    // All-zero vector
    send(16'h0000);
    drain();

    // Wide instance boundary bits
    send(16'h8001);
    drain();

    // Flush during the 2nd beat, then a fresh vector
    send(16'h00A5);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    send(16'h0010);
    drain();

    // Flush while idle blocks acceptance
    flush = 1'b1;
    vec = 16'h0003;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    step();

    // Asynchronous reset mid-vector
    out_ready = 1'b0;
    send(16'h00A5);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid0", 32'(if0.out_valid), 0);
    check_eq("rst_out_valid2", 32'(if2.out_valid), 0);
    check_eq("rst_busy1", 32'(busy1), 0);
    check_eq("rst_in_ready0", 32'(if0.in_ready), 1);
    for (int m = 0; m < 3; m++) begin
      act[m] = 1'b0;
      exp_q[m].delete();
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0:       vec = 16'h0000;
        1:       vec = 16'(1) << $urandom_range(0, 15);
        default: vec = 16'($urandom);
      endcase
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
